// File: rtl/uart_pkg.sv
// Shared definitions for the USART receive path: parity modes, FSM encoding,
// legal frame widths and the parity decision helpers.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } rx_state_t;

    // Modes 5..7 behave like PAR_NONE, so only 1..4 expect a parity bit.
    function automatic logic parity_enabled(input logic [2:0] m);
        return (m >= PAR_EVEN) && (m <= PAR_SPACE);
    endfunction

    // x is the XOR of the data bits, p the received parity bit.
    function automatic logic parity_fail(input logic [2:0] m, input logic x, input logic p);
        logic f;
        f = 1'b0;
        case (m)
            PAR_EVEN:  f = x ^ p;
            PAR_ODD:   f = ~(x ^ p);
            PAR_MARK:  f = ~p;
            PAR_SPACE: f = p;
            default:   f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating event counter; a same-cycle inc and clr restarts the count at 1.
module uart_err_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // Clear has lower priority than a new event so that event is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && clr)
            count <= WIDTH'(1);
        else if (clr)
            count <= '0;
        else if (inc && !(&count))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/uart_rx_parity_unit.sv
// RX parity accumulator/checker: deserialises LSB-first data bits, checks the
// trailing parity bit and keeps sticky/counted parity error status.
module uart_rx_parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               mode,
    input  logic                     frame_start,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     abort,
    input  logic                     err_clr,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     parity_err,
    output logic                     busy,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    rx_state_t             state_q, state_d;
    logic [2:0]            mode_q;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_nxt;
    logic [CNT_W-1:0]      cnt_q;
    logic                  xacc_q;
    logic                  perr_q;
    logic                  shift_en;
    logic                  par_cap;
    logic                  last_bit;

    assign last_bit = (cnt_q == LAST_IDX);

    // Shift register value with bit_in dropped into slot cnt_q.
    for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_slot
        assign shreg_nxt[k] = (cnt_q == CNT_W'(k)) ? bit_in : shreg_q[k];
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and datapath enables; frame_start overrides everything else.
    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        par_cap  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_DATA: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (bit_valid) begin
                    shift_en = 1'b1;
                    if (last_bit)
                        state_d = parity_enabled(mode_q) ? ST_PARITY : ST_DONE;
                end
            end
            ST_PARITY: begin
                if (abort)
                    state_d = ST_IDLE;
                else if (bit_valid) begin
                    par_cap = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (frame_start) begin
            state_d  = ST_DATA;
            shift_en = 1'b0;
            par_cap  = 1'b0;
        end
    end

    // Frame accumulator: latched mode, data bits, bit index and running XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= PAR_NONE;
            shreg_q <= '0;
            cnt_q   <= '0;
            xacc_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else if (frame_start) begin
            mode_q  <= mode;
            shreg_q <= '0;
            cnt_q   <= '0;
            xacc_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else if (shift_en) begin
            shreg_q <= shreg_nxt;
            cnt_q   <= cnt_q + 1'b1;
            xacc_q  <= xacc_q ^ bit_in;
            perr_q  <= 1'b0;
        end else if (par_cap) begin
            perr_q  <= parity_fail(mode_q, xacc_q, bit_in);
        end
    end

    // Word register, loaded on the edge entering DONE so it is valid with data_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data_out <= '0;
        else if (shift_en && (state_d == ST_DONE))
            data_out <= shreg_nxt;
        else if (par_cap)
            data_out <= shreg_q;
    end

    assign data_valid = (state_q == ST_DONE);
    assign parity_err = data_valid && perr_q;
    assign busy       = (state_q == ST_DATA) || (state_q == ST_PARITY);

    // Sticky flag: a new error wins over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_sticky <= 1'b0;
        else if (parity_err)
            err_sticky <= 1'b1;
        else if (err_clr)
            err_sticky <= 1'b0;
    end

    uart_err_counter #(
        .WIDTH (ERR_CNT_WIDTH)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (parity_err),
        .clr   (err_clr),
        .count (err_count)
    );

endmodule

// File: tb/tb_uart_rx_parity_unit.sv
// Directed bench: four instances (8/8, 8/2, 9/8, 5/8 data/counter widths)
// share the serial/mode/control inputs but have private strobes.
module tb_uart_rx_parity_unit;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode;
    logic       bit_in, abort, err_clr;
    logic [3:0] fs_v, bv_v;

    logic [7:0] dout0, dout1;
    logic [8:0] dout2;
    logic [4:0] dout3;
    logic [3:0] dv, perr, busy, sticky;
    logic [7:0] cnt0, cnt2, cnt3;
    logic [1:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt0 = 0;

    always #5 clk = ~clk;

    uart_rx_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(8)) u_d0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(fs_v[0]), .bit_valid(bv_v[0]),
        .bit_in(bit_in), .abort(abort), .err_clr(err_clr), .data_out(dout0), .data_valid(dv[0]),
        .parity_err(perr[0]), .busy(busy[0]), .err_sticky(sticky[0]), .err_count(cnt0));
    uart_rx_parity_unit #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2)) u_d1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(fs_v[1]), .bit_valid(bv_v[1]),
        .bit_in(bit_in), .abort(abort), .err_clr(err_clr), .data_out(dout1), .data_valid(dv[1]),
        .parity_err(perr[1]), .busy(busy[1]), .err_sticky(sticky[1]), .err_count(cnt1));
    uart_rx_parity_unit #(.DATA_WIDTH(9), .ERR_CNT_WIDTH(8)) u_d2 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(fs_v[2]), .bit_valid(bv_v[2]),
        .bit_in(bit_in), .abort(abort), .err_clr(err_clr), .data_out(dout2), .data_valid(dv[2]),
        .parity_err(perr[2]), .busy(busy[2]), .err_sticky(sticky[2]), .err_count(cnt2));
    uart_rx_parity_unit #(.DATA_WIDTH(5), .ERR_CNT_WIDTH(8)) u_d3 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .frame_start(fs_v[3]), .bit_valid(bv_v[3]),
        .bit_in(bit_in), .abort(abort), .err_clr(err_clr), .data_out(dout3), .data_valid(dv[3]),
        .parity_err(perr[3]), .busy(busy[3]), .err_sticky(sticky[3]), .err_count(cnt3));

    // Counts data_valid pulses of instance 0.
    always @(negedge clk) if (dv[0] === 1'b1) dv_cnt0++;

    // All stimulus tasks are entered and left on a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start(input int i, input logic [2:0] m);
        fs_v[i] = 1'b1;
        mode    = m;
        @(negedge clk);
        fs_v[i] = 1'b0;
    endtask

    task automatic sbit(input int i, input logic b);
        bv_v[i] = 1'b1;
        bit_in  = b;
        @(negedge clk);
        bv_v[i] = 1'b0;
    endtask

    task automatic send_bits(input int i, input logic [8:0] d, input int n);
        for (int k = 0; k < n; k++) sbit(i, d[k]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mode = 3'd0; bit_in = 1'b0; abort = 1'b0; err_clr = 1'b0;
        fs_v = 4'h0; bv_v = 4'h0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %0h exp 0", dout0); end
        n_tests++; if (dv !== 4'h0) begin n_fail++; $display("FAIL reset_dv got %0h exp 0", dv); end
        n_tests++; if (perr !== 4'h0) begin n_fail++; $display("FAIL reset_perr got %0h exp 0", perr); end
        n_tests++; if (busy !== 4'h0) begin n_fail++; $display("FAIL reset_busy got %0h exp 0", busy); end
        n_tests++; if (sticky !== 4'h0) begin n_fail++; $display("FAIL reset_sticky got %0h exp 0", sticky); end
        n_tests++; if (cnt0 !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %0h exp 0", cnt0); end
    endtask

    task automatic test_even();
        start(0, PAR_EVEN);
        n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL even_busy got %0b exp 1", busy[0]); end
        send_bits(0, 9'h0A5, 8);
        n_tests++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL even_wait_par got %0b exp 0", dv[0]); end
        sbit(0, 1'b0);
        n_tests++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL even_dv got %0b exp 1", dv[0]); end
        n_tests++; if (dout0 !== 8'hA5) begin n_fail++; $display("FAIL even_data got %0h exp a5", dout0); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL even_perr got %0b exp 0", perr[0]); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL even_busy_done got %0b exp 0", busy[0]); end
        tick();
        n_tests++; if (dv[0] !== 1'b0) begin n_fail++; $display("FAIL even_dv_pulse got %0b exp 0", dv[0]); end
        n_tests++; if (dout0 !== 8'hA5) begin n_fail++; $display("FAIL even_hold got %0h exp a5", dout0); end
        n_tests++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL even_cnt got %0d exp 0", cnt0); end
    endtask

    task automatic test_odd();
        start(0, PAR_ODD);
        send_bits(0, 9'h0A5, 8);
        sbit(0, 1'b0);
        n_tests++; if (perr[0] !== 1'b1) begin n_fail++; $display("FAIL odd_perr got %0b exp 1", perr[0]); end
        n_tests++; if (sticky[0] !== 1'b0) begin n_fail++; $display("FAIL odd_sticky_early got %0b exp 0", sticky[0]); end
        tick();
        n_tests++; if (sticky[0] !== 1'b1) begin n_fail++; $display("FAIL odd_sticky got %0b exp 1", sticky[0]); end
        n_tests++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL odd_cnt got %0d exp 1", cnt0); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL odd_perr_pulse got %0b exp 0", perr[0]); end
    endtask

    task automatic test_mark_space();
        start(0, PAR_MARK);
        send_bits(0, 9'h000, 8);
        sbit(0, 1'b0);
        n_tests++; if (perr[0] !== 1'b1) begin n_fail++; $display("FAIL mark_perr got %0b exp 1", perr[0]); end
        tick();
        n_tests++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL mark_cnt got %0d exp 2", cnt0); end
        start(0, PAR_SPACE);
        send_bits(0, 9'h000, 8);
        sbit(0, 1'b0);
        n_tests++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL space_dv got %0b exp 1", dv[0]); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL space_perr got %0b exp 0", perr[0]); end
        tick();
        n_tests++; if (cnt0 !== 8'd2) begin n_fail++; $display("FAIL space_cnt got %0d exp 2", cnt0); end
    endtask

    task automatic test_no_parity();
        start(0, 3'd6);
        send_bits(0, 9'h03C, 8);
        n_tests++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL nopar_dv got %0b exp 1", dv[0]); end
        n_tests++; if (dout0 !== 8'h3C) begin n_fail++; $display("FAIL nopar_data got %0h exp 3c", dout0); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL nopar_perr got %0b exp 0", perr[0]); end
        tick();
        sbit(0, 1'b1);
        n_tests++; if ({busy[0], dv[0]} !== 2'b00) begin n_fail++; $display("FAIL nopar_extra_bit got %0b exp 00", {busy[0], dv[0]}); end
    endtask

    task automatic test_abort();
        int snap;
        snap = dv_cnt0;
        start(0, PAR_EVEN);
        send_bits(0, 9'h00F, 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b exp 0", busy[0]); end
        tick(); tick();
        n_tests++; if (dv_cnt0 != snap) begin n_fail++; $display("FAIL abort_dv got %0d pulses exp 0", dv_cnt0 - snap); end
        n_tests++; if (dout0 !== 8'h3C) begin n_fail++; $display("FAIL abort_hold got %0h exp 3c", dout0); end
    endtask

    task automatic test_restart();
        int snap;
        snap = dv_cnt0;
        start(0, PAR_EVEN);
        send_bits(0, 9'h01F, 5);
        start(0, PAR_EVEN);
        n_tests++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %0b exp 1", busy[0]); end
        send_bits(0, 9'h05A, 8);
        sbit(0, 1'b0);
        n_tests++; if (dout0 !== 8'h5A) begin n_fail++; $display("FAIL restart_data got %0h exp 5a", dout0); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL restart_perr got %0b exp 0", perr[0]); end
        tick();
        n_tests++; if (dv_cnt0 - snap != 1) begin n_fail++; $display("FAIL restart_dv got %0d pulses exp 1", dv_cnt0 - snap); end
    endtask

    task automatic test_idle_bits();
        int snap;
        snap = dv_cnt0;
        sbit(0, 1'b1);
        sbit(0, 1'b0);
        tick();
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %0b exp 0", busy[0]); end
        n_tests++; if (dv_cnt0 != snap) begin n_fail++; $display("FAIL idle_dv got %0d pulses exp 0", dv_cnt0 - snap); end
        n_tests++; if (dout0 !== 8'h5A) begin n_fail++; $display("FAIL idle_hold got %0h exp 5a", dout0); end
    endtask

    task automatic test_back_to_back();
        start(0, PAR_EVEN);
        send_bits(0, 9'h00F, 8);
        sbit(0, 1'b0);
        n_tests++; if (dv[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_dv1 got %0b exp 1", dv[0]); end
        n_tests++; if (dout0 !== 8'h0F) begin n_fail++; $display("FAIL b2b_data1 got %0h exp 0f", dout0); end
        start(0, PAR_ODD);
        n_tests++; if ({busy[0], dv[0]} !== 2'b10) begin n_fail++; $display("FAIL b2b_restart got %0b exp 10", {busy[0], dv[0]}); end
        send_bits(0, 9'h001, 8);
        sbit(0, 1'b0);
        n_tests++; if (dout0 !== 8'h01) begin n_fail++; $display("FAIL b2b_data2 got %0h exp 01", dout0); end
        n_tests++; if (perr[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_perr2 got %0b exp 0", perr[0]); end
        tick();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        for (int n = 1; n <= 5; n++) begin
            start(1, PAR_ODD);
            send_bits(1, 9'h0A5, 8);
            sbit(1, 1'b0);
            n_tests++; if (perr[1] !== 1'b1) begin n_fail++; $display("FAIL sat_perr_%0d got %0b exp 1", n, perr[1]); end
            tick();
            exp_cnt = (n > 3) ? 2'd3 : 2'(n);
            n_tests++; if (cnt1 !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt_%0d got %0d exp %0d", n, cnt1, exp_cnt); end
        end
        start(1, PAR_ODD);
        send_bits(1, 9'h0A5, 8);
        sbit(1, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++; if (cnt1 !== 2'd1) begin n_fail++; $display("FAIL clr_err_cnt got %0d exp 1", cnt1); end
        n_tests++; if (sticky[1] !== 1'b1) begin n_fail++; $display("FAIL clr_err_sticky got %0b exp 1", sticky[1]); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL clr_cnt got %0d exp 0", cnt1); end
        n_tests++; if (sticky[1] !== 1'b0) begin n_fail++; $display("FAIL clr_sticky got %0b exp 0", sticky[1]); end
    endtask

    task automatic test_widths();
        start(2, PAR_EVEN);
        send_bits(2, 9'h1FF, 9);
        sbit(2, 1'b1);
        n_tests++; if (dv[2] !== 1'b1) begin n_fail++; $display("FAIL w9_dv got %0b exp 1", dv[2]); end
        n_tests++; if (dout2 !== 9'h1FF) begin n_fail++; $display("FAIL w9_data got %0h exp 1ff", dout2); end
        n_tests++; if (perr[2] !== 1'b0) begin n_fail++; $display("FAIL w9_perr got %0b exp 0", perr[2]); end
        tick();
        start(3, PAR_EVEN);
        send_bits(3, 9'h01F, 5);
        sbit(3, 1'b1);
        n_tests++; if (dout3 !== 5'h1F) begin n_fail++; $display("FAIL w5_data got %0h exp 1f", dout3); end
        n_tests++; if (perr[3] !== 1'b0) begin n_fail++; $display("FAIL w5_perr got %0b exp 0", perr[3]); end
        tick();
        start(3, PAR_EVEN);
        send_bits(3, 9'h01F, 5);
        sbit(3, 1'b0);
        n_tests++; if (perr[3] !== 1'b1) begin n_fail++; $display("FAIL w5_bad_perr got %0b exp 1", perr[3]); end
        tick();
    endtask

    task automatic test_async_reset();
        start(0, PAR_ODD);
        send_bits(0, 9'h0A5, 8);
        sbit(0, 1'b0);
        tick();
        n_tests++; if (cnt0 !== 8'd1) begin n_fail++; $display("FAIL pre_rst_cnt got %0d exp 1", cnt0); end
        start(0, PAR_EVEN);
        send_bits(0, 9'h007, 3);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %0b exp 0", busy[0]); end
        n_tests++; if (cnt0 !== 8'd0) begin n_fail++; $display("FAIL arst_cnt got %0d exp 0", cnt0); end
        n_tests++; if (sticky[0] !== 1'b0) begin n_fail++; $display("FAIL arst_sticky got %0b exp 0", sticky[0]); end
        n_tests++; if (dout0 !== 8'h00) begin n_fail++; $display("FAIL arst_dout got %0h exp 0", dout0); end
        tick();
        rst_n = 1'b1;
        tick();
        sbit(0, 1'b1);
        n_tests++; if ({busy[0], dv[0]} !== 2'b00) begin n_fail++; $display("FAIL arst_idle got %0b exp 00", {busy[0], dv[0]}); end
    endtask

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_mark_space();
        test_no_parity();
        test_abort();
        test_restart();
        test_idle_bits();
        test_back_to_back();
        test_saturation();
        test_widths();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_parity_unit.md
# uart_rx_parity_unit

Serial parity accumulator and checker for the USART receive path. It sits between the RX bit sampler and the RX data register. It deserialises LSB-first data bits as the sampler strobes them and checks the trailing parity bit against a per-frame mode: none, even, odd, mark or space. It reports the word, a per-frame error pulse, a sticky error flag and a saturating error count.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame; legal range 5..9.
- ERR_CNT_WIDTH, 8: width of the saturating parity-error counter; minimum 2.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  3  parity mode; sampled only on frame_start. 0 = none, 1 = even, 2 = odd, 3 = mark, 4 = space, 5..7 = treated as none.
- frame_start  in  1  one-cycle strobe at the start bit; clears the accumulator and begins a frame.
- bit_valid  in  1  one-cycle strobe marking a sampled bit on bit_in.
- bit_in  in  1  sampled serial bit.
- abort  in  1  drops the current frame (e.g. on framing error).
- err_clr  in  1  clears err_sticky and err_count.
- data_out  out  DATA_WIDTH  last completed word; bit k is the k-th received bit.
- data_valid  out  1  one-cycle pulse when data_out is updated.
- parity_err  out  1  one-cycle pulse, coincident with data_valid, when parity failed.
- busy  out  1  high while a frame is in progress.
- err_sticky  out  1  set on any parity error; held until err_clr.
- err_count  out  ERR_CNT_WIDTH  number of parity errors, saturating at all-ones.

## Operation
- FSM states:
  - IDLE: reset state.
  - DATA: counting data bits.
  - PARITY: waiting for the parity bit.
  - DONE: single-cycle output state.
- IDLE -> DATA on frame_start.
  - mode is latched on this edge.
  - Shift register, bit counter and running XOR are cleared.
- DATA: each bit_valid shifts bit_in into position cnt and XORs it into the running parity.
  - After bit DATA_WIDTH-1, go to PARITY if the latched mode is 1..4.
  - Otherwise go to DONE.
- PARITY: the next bit_valid captures the parity bit p and goes to DONE. The check, with x = XOR of the data bits:
  - even: error if x^p = 1.
  - odd: error if x^p = 0.
  - mark: error if p = 0.
  - space: error if p = 1.
  - none: never an error.
- DONE:
  - data_out is loaded from the shift register.
  - data_valid = 1, and parity_err is driven from the check result.
  - Then go to IDLE.
- err_sticky / err_count:
  - On a parity_err cycle, set err_sticky and increment err_count unless it is all-ones.
  - err_clr alone clears both.
  - err_clr together with an error in the same cycle gives err_sticky = 1 and err_count = 1.
- Precedence, per cycle:
  - frame_start beats abort, which beats bit_valid.
  - frame_start in any state, including mid-frame, restarts the frame. The interrupted frame produces no data_valid.
  - abort in DATA or PARITY returns to IDLE with no data_valid.
  - bit_valid in IDLE or DONE is ignored.
- data_out holds its value between DONE cycles.

## Timing
- Reset values: all outputs 0, state IDLE, latched mode = none.
- busy = 1 in DATA and PARITY only. It rises the cycle after frame_start.
- Latency: data_valid and parity_err are asserted in the cycle after the edge that accepted the final bit, whether that is the last data bit or the parity bit.
- err_sticky and err_count update on the clock edge that ends the DONE cycle, so they are visible one cycle after the parity_err pulse.
- Back-to-back frames:
  - frame_start in the DONE cycle is accepted. DONE outputs still assert that cycle, and the next state is DATA.
  - The minimum inter-frame gap is 0 cycles.
- Asserting rst_n low mid-frame immediately forces IDLE and zeros all outputs, including err_count.

## Structure
- The shared package uart_pkg holds:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE);
  - the FSM state encoding;
  - the DATA_WIDTH legal-range constants.
- Sub-module uart_err_counter is a parametrised saturating counter with inc and clr, where inc wins with result 1. The RX framing-error logic reuses it.

## Test plan
- Even mode, DATA_WIDTH = 8: bits 0xA5 sent LSB-first, then p = 0 -> data_out = 0xA5, data_valid pulses 1 cycle, parity_err = 0, err_count = 0.
- Odd mode: 0xA5 with p = 0 -> parity_err = 1, err_sticky = 1, err_count = 1 one cycle later.
- Mark mode, 0x00 with p = 0 -> parity_err = 1. Space mode, 0x00 with p = 0 -> no error. Mode 6, 0x3C -> data_valid after the 8th bit with no parity bit consumed.
- Mid-frame events:
  - abort after 4 bits -> no data_valid, busy drops next cycle.
  - frame_start after 5 bits, then a full 0x5A frame -> single data_valid with data_out = 0x5A.
  - bit_valid in IDLE -> no effect.
- ERR_CNT_WIDTH = 2, five odd-mode error frames -> err_count saturates at 3. err_clr in the same cycle as the next error -> err_count = 1, err_sticky = 1.
- DATA_WIDTH = 9 and DATA_WIDTH = 5, even mode, all-ones data with the correct p -> no error.
  - rst_n pulsed low mid-frame -> all outputs 0 and state IDLE, asynchronously.
